// File: rtl/snn_pkg.sv
// Shared SNN constants: default trace/weight widths, weight bounds, learning shift.
// Also holds the STDP pipeline state type and a helper that sizes the signed update sum.
package snn_pkg;

    localparam int unsigned TRACE_WIDTH  = 8;
    localparam int unsigned WEIGHT_WIDTH = 8;
    localparam int unsigned LEARN_SHIFT  = 2;
    localparam int unsigned W_INIT       = 128;
    localparam int unsigned W_MIN        = 0;
    localparam int unsigned W_MAX        = 255;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } stdp_state_e;

    // Two extra bits give a sign bit plus headroom for weight + trace or weight - trace.
    function automatic int unsigned sum_width(input int unsigned trace_w,
                                              input int unsigned weight_w);
        return ((trace_w > weight_w) ? trace_w : weight_w) + 2;
    endfunction

endpackage

// File: rtl/stdp_sat_add.sv
// Combinational signed weight + ltp - ltd with clamp to [w_min, w_max].
// sat_c flags that the result was clamped.
module stdp_sat_add
    import snn_pkg::*;
#(
    parameter int unsigned WEIGHT_W = WEIGHT_WIDTH,
    parameter int unsigned DELTA_W  = TRACE_WIDTH
) (
    input  logic [WEIGHT_W-1:0] weight,
    input  logic [DELTA_W-1:0]  ltp,
    input  logic [DELTA_W-1:0]  ltd,
    input  logic [WEIGHT_W-1:0] w_min,
    input  logic [WEIGHT_W-1:0] w_max,
    output logic [WEIGHT_W-1:0] result_c,
    output logic                sat_c
);

    localparam int unsigned SUM_W = sum_width(DELTA_W, WEIGHT_W);

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] lo;
    logic signed [SUM_W-1:0] hi;

    always_comb begin
        sum      = $signed(SUM_W'(weight)) + $signed(SUM_W'(ltp)) - $signed(SUM_W'(ltd));
        lo       = $signed(SUM_W'(w_min));
        hi       = $signed(SUM_W'(w_max));
        result_c = WEIGHT_W'(sum);
        sat_c    = 1'b0;
        if (sum < lo) begin
            result_c = w_min;
            sat_c    = 1'b1;
        end else if (sum > hi) begin
            result_c = w_max;
            sat_c    = 1'b1;
        end
    end

endmodule

// File: rtl/stdp_weight_update.sv
// Two-stage STDP weight update: capture shifted traces on spikes, then apply a
// clamped signed delta to the registered weight. Synchronous load overrides learning.
module stdp_weight_update
    import snn_pkg::*;
#(
    parameter int unsigned P_TRACE_WIDTH  = TRACE_WIDTH,
    parameter int unsigned P_WEIGHT_WIDTH = WEIGHT_WIDTH,
    parameter int unsigned P_SHIFT        = LEARN_SHIFT,
    parameter int unsigned P_W_INIT       = W_INIT,
    parameter int unsigned P_W_MIN        = W_MIN,
    parameter int unsigned P_W_MAX        = W_MAX
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_learn_en,
    input  logic                      i_pre_spike,
    input  logic                      i_post_spike,
    input  logic [P_TRACE_WIDTH-1:0]  i_pre_trace,
    input  logic [P_TRACE_WIDTH-1:0]  i_post_trace,
    input  logic                      i_w_load,
    input  logic [P_WEIGHT_WIDTH-1:0] i_w_data,
    output logic [P_WEIGHT_WIDTH-1:0] o_weight,
    output logic                      o_update_valid,
    output logic                      o_sat
);

    localparam logic [P_WEIGHT_WIDTH-1:0] W_INIT_V = P_WEIGHT_WIDTH'(P_W_INIT);
    localparam logic [P_WEIGHT_WIDTH-1:0] W_MIN_V  = P_WEIGHT_WIDTH'(P_W_MIN);
    localparam logic [P_WEIGHT_WIDTH-1:0] W_MAX_V  = P_WEIGHT_WIDTH'(P_W_MAX);

    stdp_state_e               state_q;
    stdp_state_e               state_d;
    logic [P_TRACE_WIDTH-1:0]  ltp_q;
    logic [P_TRACE_WIDTH-1:0]  ltd_q;
    logic [P_TRACE_WIDTH-1:0]  ltp_d;
    logic [P_TRACE_WIDTH-1:0]  ltd_d;
    logic                      accept_c;
    logic                      apply_c;
    logic [P_WEIGHT_WIDTH-1:0] new_weight_c;
    logic                      new_sat_c;

    // Next-state and stage-1 capture; load discards both the incoming spike and stage 1.
    always_comb begin
        state_d  = ST_IDLE;
        accept_c = 1'b0;
        apply_c  = 1'b0;
        ltp_d    = ltp_q;
        ltd_d    = ltd_q;
        if (!i_w_load) begin
            accept_c = i_learn_en & (i_pre_spike | i_post_spike);
            apply_c  = (state_q == ST_APPLY);
        end
        if (accept_c) begin
            state_d = ST_APPLY;
            ltp_d   = i_post_spike ? P_TRACE_WIDTH'(i_pre_trace >> P_SHIFT) : '0;
            ltd_d   = i_pre_spike ? P_TRACE_WIDTH'(i_post_trace >> P_SHIFT) : '0;
        end
    end

    stdp_sat_add #(
        .WEIGHT_W (P_WEIGHT_WIDTH),
        .DELTA_W  (P_TRACE_WIDTH)
    ) u_sat_add (
        .weight   (o_weight),
        .ltp      (ltp_q),
        .ltd      (ltd_q),
        .w_min    (W_MIN_V),
        .w_max    (W_MAX_V),
        .result_c (new_weight_c),
        .sat_c    (new_sat_c)
    );

    // Stage-1 register, weight register and the update/saturation pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= ST_IDLE;
            ltp_q          <= '0;
            ltd_q          <= '0;
            o_weight       <= W_INIT_V;
            o_update_valid <= 1'b0;
            o_sat          <= 1'b0;
        end else begin
            state_q        <= state_d;
            ltp_q          <= ltp_d;
            ltd_q          <= ltd_d;
            o_update_valid <= apply_c;
            o_sat          <= apply_c & new_sat_c;
            if (i_w_load) begin
                o_weight <= i_w_data;
            end else if (apply_c) begin
                o_weight <= new_weight_c;
            end
        end
    end

endmodule
